lsu_mem_initiator: RTL and testbench

- Load/store unit between the RV32I execute stage and the word-addressed, synchronous-read data memory.
- Issues word reads and writes to the memory.
- Sub-word stores (SB/SH) are done by read-modify-write, since the memory has only a whole-word write enable.
- Loads extract byte/halfword lanes with sign or zero extension. Stalls the pipeline via busy while a multi-cycle access is in flight.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_mem_initiator_if.sv | 34 +++
 rtl/lsu_load_align.sv | 37 +++
 rtl/lsu_mem_initiator.sv | 113 +++++++++++
 tb/tb_lsu_mem_initiator.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit:
// funct3 widths, FSM states, lane masks and the access-legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] LANE_B = 32'h0000_00ff;
  localparam logic [31:0] LANE_H = 32'h0000_ffff;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RMW
  } lsu_state_t;

  // Stores only exist as B/H/W; the unsigned encodings are load-only.
  function automatic logic lsu_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    unique case (f3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = off[0];
      F3_HU:   bad = we | off[0];
      F3_W:    bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Execute-stage request/response and data-memory bus,
// slave = LSU view, master = pipeline/memory view.
interface lsu_mem_initiator_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                     req;
  logic                     we;
  logic [2:0]               funct3;
  logic [DATA_WIDTH-1:0]    addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     busy;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     rdata_valid;
  logic                     err;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_wen;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  req, we, funct3, addr, wdata,
    output busy, rdata, rdata_valid, err,
    output mem_addr, mem_wen, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req, we, funct3, addr, wdata,
    input  busy, rdata, rdata_valid, err,
    input  mem_addr, mem_wen, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a
// memory word by byte offset and funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    unique case (1'b1)
      i_funct3 == F3_B:  o_data = {{24{w_byte[7]}}, w_byte};
      i_funct3 == F3_BU: o_data = {24'd0, w_byte};
      i_funct3 == F3_H:  o_data = {{16{w_half[15]}}, w_half};
      i_funct3 == F3_HU: o_data = {16'd0, w_half};
      default:           o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// RV32I load/store unit: word loads with lane extract,
// zero-stall SW, read-modify-write SB/SH.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input logic                clk,
  input logic                rst_n,
  lsu_mem_initiator_if.slave bus
);

  lsu_state_t                r_state;
  lsu_state_t                w_next;
  logic [ADDRESS_WIDTH+1:0]  r_addr;
  logic [2:0]                r_f3;
  logic [15:0]               r_wdata;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_rdata_valid;
  logic                      r_err;

  logic                      w_bad;
  logic                      w_accept;
  logic                      w_wen;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [ADDRESS_WIDTH-1:0]  w_maddr;
  logic [31:0]               w_mask;
  logic [31:0]               w_rep;
  logic [31:0]               w_merge;
  logic [31:0]               w_load;
  logic                      w_unused_addr;

  assign w_unused_addr = ^bus.addr[DATA_WIDTH-1:ADDRESS_WIDTH+2];

  assign w_bad    = lsu_bad(bus.we, bus.funct3, bus.addr[1:0]);
  assign w_accept = (r_state == IDLE) && bus.req;

  // Replicate store data so any lane picks it up under the mask.
  always_comb begin
    w_mask  = ((r_f3 == F3_H) ? LANE_H : LANE_B)
              << {r_addr[1:0], 3'b000};
    w_rep   = (r_f3 == F3_H) ? {2{r_wdata}}
                             : {4{r_wdata[7:0]}};
    w_merge = (bus.mem_rdata & ~w_mask) | (w_rep & w_mask);
  end

  lsu_load_align u_align (
    .i_word   (bus.mem_rdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_data   (w_load)
  );

  always_comb begin
    w_next  = r_state;
    w_wen   = 1'b0;
    w_wdata = bus.wdata;
    w_maddr = bus.addr[ADDRESS_WIDTH+1:2];
    unique case (r_state)
      IDLE: begin
        if (bus.req && !w_bad) begin
          if (!bus.we)                 w_next = LOAD;
          else if (bus.funct3 != F3_W) w_next = RMW;
          else                         w_wen  = 1'b1;
        end
      end
      LOAD: begin
        w_maddr = r_addr[ADDRESS_WIDTH+1:2];
        w_next  = IDLE;
      end
      RMW: begin
        w_maddr = r_addr[ADDRESS_WIDTH+1:2];
        w_wdata = w_merge;
        w_wen   = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_f3          <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_rdata_valid <= (r_state == LOAD);
      r_err         <= w_accept && w_bad;
      if (w_accept) begin
        r_addr  <= bus.addr[ADDRESS_WIDTH+1:0];
        r_f3    <= bus.funct3;
        r_wdata <= bus.wdata[15:0];
      end
      if (r_state == LOAD) r_rdata <= w_load;
    end
  end

  // Reset must silence the write port even mid-RMW.
  assign bus.mem_wen     = w_wen && rst_n;
  assign bus.mem_wdata   = rst_n ? w_wdata : '0;
  assign bus.mem_addr    = w_maddr;
  assign bus.busy        = (r_state != IDLE);
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench: synchronous-read memory model plus
// hand-computed load/store/RMW/error/reset vectors.
module tb_lsu_mem_initiator;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [31:0] mem [0:65535];

  lsu_mem_initiator_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus ();

  lsu_mem_initiator #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req    = 1'b1;
    bus.we     = we;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = d;
  endtask

  // Starts and ends at posedge+1 so calls chain back-to-back.
  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, f3, a, 32'h0);
    #2;
    chk({tag, "/acc_busy"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk({tag, "/ld_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "/ld_rv"}, 32'(bus.rdata_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "/rv"}, 32'(bus.rdata_valid), 32'd1);
    chk({tag, "/rdata"}, bus.rdata, exp);
    chk({tag, "/busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_sw(input string tag, input logic [31:0] a,
                       input logic [31:0] d);
    drive(1'b1, 3'b010, a, d);
    #2;
    chk({tag, "/wen"}, 32'(bus.mem_wen), 32'd1);
    chk({tag, "/wdata"}, bus.mem_wdata, d);
    chk({tag, "/busy"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk({tag, "/busy2"}, 32'(bus.busy), 32'd0);
    chk({tag, "/mem"}, mem[a[17:2]], d);
  endtask

  task automatic do_sub(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
    drive(1'b1, f3, a, d);
    #2;
    chk({tag, "/acc_wen"}, 32'(bus.mem_wen), 32'd0);
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk({tag, "/rmw_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "/rmw_wen"}, 32'(bus.mem_wen), 32'd1);
    chk({tag, "/rmw_wdata"}, bus.mem_wdata, exp);
    @(posedge clk); #1;
    chk({tag, "/post_wen"}, 32'(bus.mem_wen), 32'd0);
    chk({tag, "/mem"}, mem[a[17:2]], exp);
  endtask

  task automatic do_err(input string tag, input logic we,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] keep);
    drive(we, f3, a, 32'h5a5a_5a5a);
    #2;
    chk({tag, "/wen"}, 32'(bus.mem_wen), 32'd0);
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk({tag, "/err"}, 32'(bus.err), 32'd1);
    chk({tag, "/rv"}, 32'(bus.rdata_valid), 32'd0);
    chk({tag, "/busy"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "/err_off"}, 32'(bus.err), 32'd0);
    chk({tag, "/mem"}, mem[a[17:2]], keep);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b1, 3'b010, 32'h100, 32'hffff_ffff);
    #3;
    chk("rst/busy", 32'(bus.busy), 32'd0);
    chk("rst/wen", 32'(bus.mem_wen), 32'd0);
    chk("rst/wdata", bus.mem_wdata, 32'd0);
    chk("rst/rdata", bus.rdata, 32'd0);
    chk("rst/rv", 32'(bus.rdata_valid), 32'd0);
    chk("rst/err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    bus.req = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;

    do_sw("sw_pre", 32'h100, 32'h8899_aabb);
    do_load("lb", 3'b000, 32'h103, 32'hffff_ff88);
    do_load("lbu", 3'b100, 32'h101, 32'h0000_00aa);
    do_load("lh", 3'b001, 32'h102, 32'hffff_8899);
    do_load("lhu", 3'b101, 32'h100, 32'h0000_aabb);

    do_sub("sb", 3'b000, 32'h101, 32'h1234_5677, 32'h8899_77bb);
    do_sub("sh", 3'b001, 32'h102, 32'h0000_cafe, 32'hcafe_77bb);
    do_load("lw_rmw", 3'b010, 32'h100, 32'hcafe_77bb);

    do_sw("sw", 32'h104, 32'hdead_beef);
    do_load("lw", 3'b010, 32'h104, 32'hdead_beef);

    do_err("lw_mis", 1'b0, 3'b010, 32'h102, 32'hcafe_77bb);
    do_err("sh_mis", 1'b1, 3'b001, 32'h101, 32'hcafe_77bb);
    do_err("f3_bad", 1'b0, 3'b011, 32'h100, 32'hcafe_77bb);
    chk("err/rdata_hold", bus.rdata, 32'hdead_beef);

    drive(1'b1, 3'b000, 32'h100, 32'h0000_0055);
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk("abort/rmw_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort/wen", 32'(bus.mem_wen), 32'd0);
    chk("abort/wdata", bus.mem_wdata, 32'd0);
    chk("abort/busy", 32'(bus.busy), 32'd0);
    chk("abort/rdata", bus.rdata, 32'd0);
    chk("abort/rv", 32'(bus.rdata_valid), 32'd0);
    chk("abort/err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort/mem", mem[16'h40], 32'hcafe_77bb);
    @(posedge clk); #1;
    do_load("post_rst", 3'b010, 32'h100, 32'hcafe_77bb);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
